// File: rtl/mcm_pkg.sv
// Shared constants, coefficient tables and decode helper for the multiple-constant multiplier.
// Coefficients are the VVC 4-tap intra chroma interpolation (fC) and smoothing (fG) filters.
package mcm_pkg;

    localparam int unsigned TAPS   = 4;
    localparam int unsigned FRAC_W = 5;
    localparam int unsigned N_FRAC = 32;
    localparam int unsigned MAG_W  = 7;

    typedef struct packed {
        logic             neg;
        logic [MAG_W-1:0] mag;
    } coef_t;

    typedef coef_t [TAPS-1:0] coef_set_t;

    localparam logic signed [7:0] COEF_FC [N_FRAC][TAPS] = '{
        '{ 8'sd0,  8'sd64,  8'sd0,   8'sd0},
        '{-8'sd1,  8'sd63,  8'sd2,   8'sd0},
        '{-8'sd2,  8'sd62,  8'sd4,   8'sd0},
        '{-8'sd2,  8'sd60,  8'sd7,  -8'sd1},
        '{-8'sd2,  8'sd58,  8'sd10, -8'sd2},
        '{-8'sd3,  8'sd57,  8'sd12, -8'sd2},
        '{-8'sd4,  8'sd56,  8'sd14, -8'sd2},
        '{-8'sd4,  8'sd55,  8'sd15, -8'sd2},
        '{-8'sd4,  8'sd54,  8'sd16, -8'sd2},
        '{-8'sd5,  8'sd53,  8'sd18, -8'sd2},
        '{-8'sd6,  8'sd52,  8'sd20, -8'sd2},
        '{-8'sd6,  8'sd49,  8'sd24, -8'sd3},
        '{-8'sd6,  8'sd46,  8'sd28, -8'sd4},
        '{-8'sd5,  8'sd44,  8'sd29, -8'sd4},
        '{-8'sd4,  8'sd42,  8'sd30, -8'sd4},
        '{-8'sd4,  8'sd39,  8'sd33, -8'sd4},
        '{-8'sd4,  8'sd36,  8'sd36, -8'sd4},
        '{-8'sd4,  8'sd33,  8'sd39, -8'sd4},
        '{-8'sd4,  8'sd30,  8'sd42, -8'sd4},
        '{-8'sd4,  8'sd29,  8'sd44, -8'sd5},
        '{-8'sd4,  8'sd28,  8'sd46, -8'sd6},
        '{-8'sd3,  8'sd24,  8'sd49, -8'sd6},
        '{-8'sd2,  8'sd20,  8'sd52, -8'sd6},
        '{-8'sd2,  8'sd18,  8'sd53, -8'sd5},
        '{-8'sd2,  8'sd16,  8'sd54, -8'sd4},
        '{-8'sd2,  8'sd15,  8'sd55, -8'sd4},
        '{-8'sd2,  8'sd14,  8'sd56, -8'sd4},
        '{-8'sd2,  8'sd12,  8'sd57, -8'sd3},
        '{-8'sd2,  8'sd10,  8'sd58, -8'sd2},
        '{-8'sd1,  8'sd7,   8'sd60, -8'sd2},
        '{ 8'sd0,  8'sd4,   8'sd62, -8'sd2},
        '{ 8'sd0,  8'sd2,   8'sd63, -8'sd1}
    };

    localparam logic signed [7:0] COEF_FG [N_FRAC][TAPS] = '{
        '{8'sd16, 8'sd32, 8'sd16, 8'sd0},
        '{8'sd16, 8'sd32, 8'sd16, 8'sd0},
        '{8'sd15, 8'sd31, 8'sd17, 8'sd1},
        '{8'sd15, 8'sd31, 8'sd17, 8'sd1},
        '{8'sd14, 8'sd30, 8'sd18, 8'sd2},
        '{8'sd14, 8'sd30, 8'sd18, 8'sd2},
        '{8'sd13, 8'sd29, 8'sd19, 8'sd3},
        '{8'sd13, 8'sd29, 8'sd19, 8'sd3},
        '{8'sd12, 8'sd28, 8'sd20, 8'sd4},
        '{8'sd12, 8'sd28, 8'sd20, 8'sd4},
        '{8'sd11, 8'sd27, 8'sd21, 8'sd5},
        '{8'sd11, 8'sd27, 8'sd21, 8'sd5},
        '{8'sd10, 8'sd26, 8'sd22, 8'sd6},
        '{8'sd10, 8'sd26, 8'sd22, 8'sd6},
        '{8'sd9,  8'sd25, 8'sd23, 8'sd7},
        '{8'sd9,  8'sd25, 8'sd23, 8'sd7},
        '{8'sd8,  8'sd24, 8'sd24, 8'sd8},
        '{8'sd8,  8'sd24, 8'sd24, 8'sd8},
        '{8'sd7,  8'sd23, 8'sd25, 8'sd9},
        '{8'sd7,  8'sd23, 8'sd25, 8'sd9},
        '{8'sd6,  8'sd22, 8'sd26, 8'sd10},
        '{8'sd6,  8'sd22, 8'sd26, 8'sd10},
        '{8'sd5,  8'sd21, 8'sd27, 8'sd11},
        '{8'sd5,  8'sd21, 8'sd27, 8'sd11},
        '{8'sd4,  8'sd20, 8'sd28, 8'sd12},
        '{8'sd4,  8'sd20, 8'sd28, 8'sd12},
        '{8'sd3,  8'sd19, 8'sd29, 8'sd13},
        '{8'sd3,  8'sd19, 8'sd29, 8'sd13},
        '{8'sd2,  8'sd18, 8'sd30, 8'sd14},
        '{8'sd2,  8'sd18, 8'sd30, 8'sd14},
        '{8'sd1,  8'sd17, 8'sd31, 8'sd15},
        '{8'sd1,  8'sd17, 8'sd31, 8'sd15}
    };

    // Split each signed coefficient into sign + magnitude so lanes only shift and add.
    function automatic coef_set_t decode_coef(input logic mode, input logic [FRAC_W-1:0] frac);
        coef_set_t        s;
        logic signed [7:0] c;
        for (int t = 0; t < TAPS; t++) begin
            c        = mode ? COEF_FG[frac][t] : COEF_FC[frac][t];
            s[t].neg = c[7];
            s[t].mag = MAG_W'(c[7] ? -c : c);
        end
        return s;
    endfunction

endpackage

// File: rtl/mcm_lane.sv
// One channel: four constant products of a single sample, built from shifted copies of the sample.
// S1 holds the sample shifts (term 0 is the sample itself) and the coefficient set; S2 holds the sums.
module mcm_lane
    import mcm_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned OUT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s1_en,
    input  logic                     s2_en,
    input  logic [SAMPLE_W-1:0]      x,
    input  coef_set_t                coef,
    output logic [TAPS*OUT_W-1:0]    y
);

    localparam int unsigned TERM_W = SAMPLE_W + MAG_W - 1;

    logic [TERM_W-1:0]      term_q [MAG_W];
    coef_set_t              coef_q;
    logic [TAPS*OUT_W-1:0]  y_c;
    logic [OUT_W-1:0]       acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAG_W; i++) term_q[i] <= '0;
            coef_q <= '0;
            y      <= '0;
        end else begin
            if (s1_en) begin
                for (int i = 0; i < MAG_W; i++) term_q[i] <= TERM_W'(x) << i;
                coef_q <= coef;
            end
            if (s2_en) y <= y_c;
        end
    end

    // Sum the shifts selected by each magnitude bit, then apply the coefficient sign.
    always_comb begin
        y_c = '0;
        acc = '0;
        for (int t = 0; t < TAPS; t++) begin
            acc = '0;
            for (int i = 0; i < MAG_W; i++) begin
                if (coef_q[t].mag[i]) acc = acc + OUT_W'(term_q[i]);
            end
            y_c[t*OUT_W +: OUT_W] = coef_q[t].neg ? -acc : acc;
        end
    end

endmodule

// File: rtl/mcm_pipe.sv
// Two-stage valid/ready pipeline multiplying N_CH samples by one 4-tap VVC coefficient set.
module mcm_pipe
    import mcm_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned OUT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_CH*SAMPLE_W-1:0]    in_x,
    input  logic [FRAC_W-1:0]           in_frac,
    input  logic                        in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_CH*TAPS*OUT_W-1:0]  out_y
);

    if (OUT_W < SAMPLE_W + 8 || N_CH == 0) begin : g_bad_param
        $error("mcm_pipe: need OUT_W >= SAMPLE_W + 8 and N_CH >= 1");
    end

    logic      s1_valid;
    logic      s2_valid;
    logic      s2_load;
    logic      accept;
    coef_set_t coef_c;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign coef_c    = decode_coef(in_mode, in_frac);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s2_load)  s2_valid <= s1_valid;
        end
    end

    // Data moves only with a real transaction so idle cycles leave out_y untouched.
    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        mcm_lane #(
            .SAMPLE_W (SAMPLE_W),
            .OUT_W    (OUT_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .s1_en (accept),
            .s2_en (s2_load && s1_valid),
            .x     (in_x[c*SAMPLE_W +: SAMPLE_W]),
            .coef  (coef_c),
            .y     (out_y[c*TAPS*OUT_W +: TAPS*OUT_W])
        );
    end

endmodule

// File: tb/tb_mcm_pipe.sv
// Bench for mcm_pipe: directed filter vectors, backpressure, mid-flight reset and random streams
// compared against an integer-multiply model with an in-order expectation queue.
module tb_mcm_pipe;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned N_CH     = 4;
    localparam int unsigned OUT_W    = 16;
    localparam int unsigned XW       = N_CH * SAMPLE_W;
    localparam int unsigned YW       = N_CH * 4 * OUT_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [4:0]    in_frac;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [YW-1:0] out_y;

    mcm_pipe #(
        .SAMPLE_W (SAMPLE_W),
        .N_CH     (N_CH),
        .OUT_W    (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_frac   (in_frac),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [YW-1:0] expq [$];
    bit            held;
    logic [YW-1:0] held_y;

    int fc_tab [32][4] = '{
        '{ 0, 64,  0,  0}, '{-1, 63,  2,  0}, '{-2, 62,  4,  0}, '{-2, 60,  7, -1},
        '{-2, 58, 10, -2}, '{-3, 57, 12, -2}, '{-4, 56, 14, -2}, '{-4, 55, 15, -2},
        '{-4, 54, 16, -2}, '{-5, 53, 18, -2}, '{-6, 52, 20, -2}, '{-6, 49, 24, -3},
        '{-6, 46, 28, -4}, '{-5, 44, 29, -4}, '{-4, 42, 30, -4}, '{-4, 39, 33, -4},
        '{-4, 36, 36, -4}, '{-4, 33, 39, -4}, '{-4, 30, 42, -4}, '{-4, 29, 44, -5},
        '{-4, 28, 46, -6}, '{-3, 24, 49, -6}, '{-2, 20, 52, -6}, '{-2, 18, 53, -5},
        '{-2, 16, 54, -4}, '{-2, 15, 55, -4}, '{-2, 14, 56, -4}, '{-2, 12, 57, -3},
        '{-2, 10, 58, -2}, '{-1,  7, 60, -2}, '{ 0,  4, 62, -2}, '{ 0,  2, 63, -1}
    };

    task automatic check(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Smoothing filter follows a closed form: each pair of phases shifts weight by one.
    function automatic int coef_of(input bit mode, input int frac, input int t);
        int k;
        k = frac / 2;
        if (!mode) return fc_tab[frac][t];
        case (t)
            0:       return 16 - k;
            1:       return 32 - k;
            2:       return 16 + k;
            default: return k;
        endcase
    endfunction

    function automatic logic [YW-1:0] golden(input logic [XW-1:0] x, input int frac, input bit mode);
        logic [YW-1:0] g;
        int            v;
        g = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int t = 0; t < 4; t++) begin
                v = int'(x[c*SAMPLE_W +: SAMPLE_W]) * coef_of(mode, frac, t);
                g[(c*4+t)*OUT_W +: OUT_W] = OUT_W'(v);
            end
        end
        return g;
    endfunction

    function automatic logic [4*OUT_W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {OUT_W'(d), OUT_W'(c), OUT_W'(b), OUT_W'(a)};
    endfunction

    // One clock: check outputs against the model, record handshakes, advance past the edge.
    task automatic cycle();
        bit acc;
        bit drn;
        #1;
        acc = !rst && in_valid && in_ready;
        drn = out_valid && out_ready;
        if (!rst) begin
            if (held) begin
                check("hold_valid", YW'(out_valid), YW'(1));
                check("hold_y", out_y, held_y);
            end
            if (out_valid) begin
                if (expq.size() == 0) check("spurious_valid", YW'(out_valid), '0);
                else                  check("order_y", out_y, expq[0]);
            end
        end
        held   = !rst && out_valid && !out_ready;
        held_y = out_y;
        if (acc) expq.push_back(golden(in_x, int'(in_frac), in_mode));
        if (drn && expq.size() > 0) void'(expq.pop_front());
        if (rst) expq.delete();
        @(posedge clk);
        #1;
    endtask

    // Send one transaction into an idle pipe and check its exact 2-cycle latency and value.
    task automatic run_directed(input string tag, input logic [XW-1:0] x, input logic [4:0] frac,
                                input bit mode, input logic [YW-1:0] exp);
        in_valid  = 1'b1;
        in_x      = x;
        in_frac   = frac;
        in_mode   = mode;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        in_x     = XW'($urandom);
        in_frac  = 5'($urandom);
        in_mode  = 1'($urandom);
        check({tag, "_lat1_valid"}, YW'(out_valid), '0);
        cycle();
        check({tag, "_lat2_valid"}, YW'(out_valid), YW'(1));
        check({tag, "_y"}, out_y, exp);
        cycle();
    endtask

    initial begin
        logic [XW-1:0] bx [5];
        logic [4:0]    bf [5];
        bit            bm [5];
        int            sent;
        logic [XW-1:0] rx;
        logic [4:0]    rf;
        bit            rm;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_x      = '0;
        in_frac   = '0;
        in_mode   = 1'b0;
        held      = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        check("rst_out_valid", YW'(out_valid), '0);
        check("rst_out_y", out_y, '0);
        check("rst_in_ready", YW'(in_ready), YW'(1));

        run_directed("fc0_x200", {4{8'd200}}, 5'd0, 1'b0, {4{pack4(0, 12800, 0, 0)}});
        run_directed("fc16_mix", {8'd128, 8'd1, 8'd0, 8'd255}, 5'd16, 1'b0,
                     {pack4(-512, 4608, 4608, -512), pack4(-4, 36, 36, -4),
                      pack4(0, 0, 0, 0), pack4(-1020, 9180, 9180, -1020)});
        run_directed("fg0_x255", {4{8'd255}}, 5'd0, 1'b1, {4{pack4(4080, 8160, 4080, 0)}});
        run_directed("fc31_x255", {4{8'd255}}, 5'd31, 1'b0, {4{pack4(0, 510, 16065, -255)}});

        // Backpressure: five back-to-back sends with the sink stalled for four cycles.
        for (int k = 0; k < 5; k++) begin
            bx[k] = XW'($urandom);
            bf[k] = 5'($urandom);
            bm[k] = 1'($urandom);
        end
        sent = 0;
        for (int i = 0; i < 14; i++) begin
            out_ready = (i >= 4);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                in_x    = bx[sent];
                in_frac = bf[sent];
                in_mode = bm[sent];
            end
            #1;
            if (i == 2) begin
                check("bp_accepts_before_stall", YW'(sent), YW'(2));
                check("bp_ready_low", YW'(in_ready), '0);
            end
            if (i == 3) check("bp_ready_low2", YW'(in_ready), '0);
            if (in_valid && in_ready) sent++;
            cycle();
        end
        in_valid = 1'b0;
        check("bp_all_accepted", YW'(sent), YW'(5));
        check("bp_drained", YW'(expq.size()), '0);

        // Reset one cycle after acceptance must wipe the transaction.
        in_valid  = 1'b1;
        in_x      = {4{8'd99}};
        in_frac   = 5'd8;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_valid", YW'(out_valid), '0);
            check("rst_mid_y", out_y, '0);
            cycle();
        end
        rx = XW'($urandom);
        rf = 5'($urandom);
        rm = 1'($urandom);
        run_directed("after_rst", rx, rf, rm, golden(rx, int'(rf), rm));

        // Random valid/ready streams.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_x      = XW'($urandom);
            in_frac   = 5'($urandom);
            in_mode   = 1'($urandom);
            cycle();
        end

        // Full-rate streaming with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_x     = XW'($urandom);
            in_frac  = 5'($urandom);
            in_mode  = 1'($urandom);
            #1;
            check("tput_in_ready", YW'(in_ready), YW'(1));
            if (i >= 2) check("tput_out_valid", YW'(out_valid), YW'(1));
            cycle();
        end

        in_valid = 1'b0;
        for (int i = 0; i < 10 && expq.size() > 0; i++) cycle();
        check("final_drain", YW'(expq.size()), '0);
        cycle();
        check("final_idle_valid", YW'(out_valid), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcm_pipe.md
MCM_PIPE -- requirements
Module: mcm_pipe

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 8, unsigned reference-sample width.
REQ-002 SHALL have parameter N_CH, default 4, number of samples multiplied in parallel per transaction.
REQ-003 SHALL have parameter OUT_W, default 16, signed product width.
REQ-004 SHALL have port clk input 1, sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst input 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid input 1, transaction present.
REQ-007 SHALL have port in_ready output 1, transaction accepted this cycle when in_valid && in_ready.
REQ-008 SHALL have port in_x input N_CH*SAMPLE_W, unsigned samples; channel c is at bits [c*SAMPLE_W +: SAMPLE_W].
REQ-009 SHALL have port in_frac input 5, fractional position 0..31.
REQ-010 SHALL have port in_mode input 1: 0 selects the interpolation table fC; 1 selects the smoothing table fG.
REQ-011 SHALL have port out_valid output 1, result present.
REQ-012 SHALL have port out_ready input 1, result consumed when out_valid && out_ready.
REQ-013 SHALL have port out_y output N_CH*4*OUT_W, signed products; channel c, tap t is at bits [(c*4+t)*OUT_W +: OUT_W].

Function
REQ-014 SHALL compute out_y[c][t] = in_x[c] * COEF[in_mode][in_frac][t] exactly, for t = 0..3, with all channels sharing one coefficient set per transaction.
REQ-015 SHALL realise products with shifts, adds and subtracts only; no '*' operator on sample data.
REQ-016 SHALL zero-extend samples before any arithmetic and sign-extend negative coefficients' results to OUT_W.
REQ-017 SHALL reject elaboration (static assertion) unless OUT_W >= SAMPLE_W + 8 and N_CH >= 1.
REQ-018 SHALL use a two-stage pipeline.
- Stage S1 registers the samples, the decoded coefficient set and the shifted partial terms.
- Stage S2 registers the final sums.
- Latency from acceptance to out_valid SHALL be exactly 2 cycles with no stall.
REQ-019 SHALL sample in_frac and in_mode together with in_x on acceptance; later changes SHALL NOT affect in-flight results.
REQ-020 SHALL load S2 when S2 is empty or out_ready=1, and load S1 when S1 is empty or S2 loads.
REQ-021 SHALL drive in_ready = !s1_valid || s2_load, so throughput is 1 transaction per cycle while out_ready=1.
REQ-022 SHALL hold out_y and out_valid stable while out_valid=1 and out_ready=0, with no loss or duplication.
REQ-023 SHALL, when both stages are full and out_ready=0, deassert in_ready and freeze both stages.
REQ-024 SHALL, on simultaneous acceptance and drain, both accept the new transaction and release the current output in the same cycle.
REQ-025 SHALL produce results in strict acceptance order.

Reset
REQ-026 SHALL, while rst=1, clear s1_valid, s2_valid and out_valid to 0 and all data registers (out_y = 0), with in_ready = 1 the cycle after reset deasserts.
REQ-027 SHALL discard any in-flight transaction when rst asserts mid-operation; no result from it SHALL ever appear.

Structure
REQ-028 SHALL take the tables COEF_FC[32][4] and COEF_FG[32][4] (signed 8-bit, VVC chroma/intra smoothing values) and the tap count constant 4 from shared package mcm_pkg.
REQ-029 SHALL contain one per-channel sub-module, mcm_lane, which computes the four shift-add products for a single sample and coefficient set; mcm_pipe instantiates N_CH of them.

Verification
REQ-030 SHALL check mode 0, frac 0, all x=200: after exactly 2 cycles each channel gives {0, 12800, 0, 0}.
REQ-031 SHALL check mode 0, frac 16, x={255,0,1,128}: channel 0 gives {-1020, 9180, 9180, -1020}, channel 1 gives all 0, channel 3 gives {-512, 4608, 4608, -512}.
REQ-032 SHALL check mode 1, frac 0, x=255: each channel gives {4080, 8160, 4080, 0}.
REQ-033 SHALL check backpressure: 5 back-to-back transactions with out_ready=0 for 4 cycles.
- in_ready falls after 2 accepts.
- Outputs emerge in order, unchanged while stalled.
- The remaining 3 are accepted once out_ready=1.
REQ-034 SHALL check reset mid-flight: rst asserted 1 cycle after acceptance means out_valid stays 0 and out_y = 0 until a new transaction is accepted.
REQ-035 SHALL run random streams against a golden multiply model with random in_valid/out_ready, requiring zero mismatches and 1/cycle throughput when out_ready is held at 1.
